// File: rtl/csr_trap_ctrl_if.sv
// CSR-file side of the trap controller: muxed write port, read address and
// registered read data (valid one cycle after raddr_o).
interface csr_trap_ctrl_if;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] wdata_o;
  logic [31:0] raddr_o;
  logic [31:0] rdata_i;

  modport master (
    output we_o,
    output waddr_o,
    output wdata_o,
    output raddr_o,
    input  rdata_i
  );

  modport slave (
    input  we_o,
    input  waddr_o,
    input  wdata_o,
    input  raddr_o,
    output rdata_i
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/return sequencer: steals the CSR port to save mepc/mcause/mstatus and redirect the PC.
// Optional feature: define CSR_TRAP_VECTORED_EN for vectored interrupt targets (mtvec mode 01).
module csr_trap_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ecall_i,
  input  logic                  ebreak_i,
  input  logic                  mret_i,
  input  logic                  int_req_i,
  input  logic [31:0]           inst_addr_i,
  input  logic                  ex_we_i,
  input  logic [31:0]           ex_waddr_i,
  input  logic [31:0]           ex_wdata_i,
  input  logic [31:0]           ex_raddr_i,
  csr_trap_ctrl_if.master       csr,
  output logic                  hold_o,
  output logic                  jump_o,
  output logic [31:0]           jump_addr_o
);

  typedef enum logic [2:0] {
    IDLE,
    RD_STATUS,
    RD_VEC,
    RD_EPC,
    WR_EPC,
    WR_CAUSE,
    WR_STATUS,
    JUMP
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  state_t      state;
  state_t      state_nxt;

  logic        mie_shadow;
  logic        is_mret_q;
  logic        is_int_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] mstatus_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;

  logic        take_int;
  logic        accept;
  logic [31:0] status_new;
  logic [31:0] trap_target;

  assign take_int = int_req_i & mie_shadow;
  // Gating with rst keeps hold_o low while reset is asserted even if a strobe is high.
  assign accept   = rst & (state == IDLE) & (ecall_i | ebreak_i | mret_i | take_int);

  // Trap: MPIE <= MIE, MIE <= 0.  Return: MIE <= MPIE, MPIE <= 1.
  assign status_new = is_mret_q
    ? {mstatus_q[31:8], 1'b1,         mstatus_q[6:4], mstatus_q[7], mstatus_q[2:0]}
    : {mstatus_q[31:8], mstatus_q[3], mstatus_q[6:4], 1'b0,         mstatus_q[2:0]};

`ifdef CSR_TRAP_VECTORED_EN
  assign trap_target = (is_int_q && (mtvec_q[1:0] == 2'b01))
                     ? {mtvec_q[31:2], 2'b00} + 32'd28
                     : {mtvec_q[31:2], 2'b00};
`else
  logic unused_vec;
  assign unused_vec  = ^{mtvec_q[1:0], is_int_q};
  assign trap_target = {mtvec_q[31:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (accept) state_nxt = RD_STATUS;
      RD_STATUS: state_nxt = is_mret_q ? RD_EPC : RD_VEC;
      RD_VEC:    state_nxt = WR_EPC;
      RD_EPC:    state_nxt = WR_STATUS;
      WR_EPC:    state_nxt = WR_CAUSE;
      WR_CAUSE:  state_nxt = WR_STATUS;
      WR_STATUS: state_nxt = JUMP;
      JUMP:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    csr.we_o    = 1'b0;
    csr.waddr_o = '0;
    csr.wdata_o = '0;
    csr.raddr_o = '0;
    hold_o      = 1'b1;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    unique case (state)
      IDLE: begin
        csr.we_o    = ex_we_i;
        csr.waddr_o = ex_waddr_i;
        csr.wdata_o = ex_wdata_i;
        csr.raddr_o = ex_raddr_i;
        hold_o      = accept;
      end
      RD_STATUS: csr.raddr_o = {20'd0, ADDR_MSTATUS};
      RD_VEC:    csr.raddr_o = {20'd0, ADDR_MTVEC};
      RD_EPC:    csr.raddr_o = {20'd0, ADDR_MEPC};
      WR_EPC: begin
        csr.we_o    = 1'b1;
        csr.waddr_o = {20'd0, ADDR_MEPC};
        csr.wdata_o = epc_q;
      end
      WR_CAUSE: begin
        csr.we_o    = 1'b1;
        csr.waddr_o = {20'd0, ADDR_MCAUSE};
        csr.wdata_o = cause_q;
      end
      WR_STATUS: begin
        csr.we_o    = 1'b1;
        csr.waddr_o = {20'd0, ADDR_MSTATUS};
        csr.wdata_o = status_new;
      end
      JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = is_mret_q ? mepc_q : trap_target;
      end
    endcase
  end

  // Read data lags raddr_o by one cycle, so each value is captured in the state after its read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_shadow <= 1'b0;
      is_mret_q  <= 1'b0;
      is_int_q   <= 1'b0;
      cause_q    <= '0;
      epc_q      <= '0;
      mstatus_q  <= '0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
    end else begin
      if (accept) begin
        epc_q     <= inst_addr_i;
        is_mret_q <= ~ecall_i & ~ebreak_i & mret_i;
        is_int_q  <= ~ecall_i & ~ebreak_i & ~mret_i;
        cause_q   <= ecall_i  ? CAUSE_ECALL  :
                     ebreak_i ? CAUSE_EBREAK : CAUSE_TIMER;
      end
      if ((state == RD_VEC) || (state == RD_EPC)) mstatus_q <= csr.rdata_i;
      if (state == WR_EPC) mtvec_q <= csr.rdata_i;
      if ((state == WR_STATUS) && is_mret_q) mepc_q <= csr.rdata_i;

      if (state == WR_STATUS) begin
        mie_shadow <= status_new[3];
      end else if ((state == IDLE) && ex_we_i && (ex_waddr_i[11:0] == ADDR_MSTATUS)) begin
        mie_shadow <= ex_wdata_i[3];
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a small registered CSR-file model on the bus.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        model_clr;
  logic        ecall_i, ebreak_i, mret_i, int_req_i;
  logic [31:0] inst_addr_i;
  logic        ex_we_i;
  logic [31:0] ex_waddr_i, ex_wdata_i, ex_raddr_i;
  logic        hold_o, jump_o;
  logic [31:0] jump_addr_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] m_status, m_tvec, m_epc, m_cause;
  int unsigned n_status_wr;
  int unsigned status_wr_snap;

`ifdef CSR_TRAP_VECTORED_EN
  localparam logic [31:0] VEC_EXP = 32'h21C;
`else
  localparam logic [31:0] VEC_EXP = 32'h200;
`endif

  always #5 clk = ~clk;

  csr_trap_ctrl_if csr_bus ();

  csr_trap_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ecall_i     (ecall_i),
    .ebreak_i    (ebreak_i),
    .mret_i      (mret_i),
    .int_req_i   (int_req_i),
    .inst_addr_i (inst_addr_i),
    .ex_we_i     (ex_we_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_wdata_i  (ex_wdata_i),
    .ex_raddr_i  (ex_raddr_i),
    .csr         (csr_bus.master),
    .hold_o      (hold_o),
    .jump_o      (jump_o),
    .jump_addr_o (jump_addr_o)
  );

  // CSR file: writes on the edge, read data registered one cycle behind raddr_o.
  always_ff @(posedge clk) begin
    if (model_clr) begin
      m_status        <= '0;
      m_tvec          <= '0;
      m_epc           <= '0;
      m_cause         <= '0;
      n_status_wr     <= 0;
      csr_bus.rdata_i <= '0;
    end else begin
      if (csr_bus.we_o) begin
        case (csr_bus.waddr_o[11:0])
          12'h300: begin
            m_status    <= csr_bus.wdata_o;
            n_status_wr <= n_status_wr + 1;
          end
          12'h305: m_tvec  <= csr_bus.wdata_o;
          12'h341: m_epc   <= csr_bus.wdata_o;
          12'h342: m_cause <= csr_bus.wdata_o;
          default: ;
        endcase
      end
      case (csr_bus.raddr_o[11:0])
        12'h300: csr_bus.rdata_i <= m_status;
        12'h305: csr_bus.rdata_i <= m_tvec;
        12'h341: csr_bus.rdata_i <= m_epc;
        12'h342: csr_bus.rdata_i <= m_cause;
        default: csr_bus.rdata_i <= '0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe_wr(input logic [31:0] addr, input logic [31:0] data);
    ex_we_i    = 1'b1;
    ex_waddr_i = addr;
    ex_wdata_i = data;
    cyc();
    ex_we_i    = 1'b0;
  endtask

  // Entered in the accept cycle with the event strobe(s) already driven.
  task automatic trap_seq(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] status, input logic [31:0] jaddr, input bit inject);
    #1 check({tag, "_hold_T"}, 32'(hold_o), 32'h1);
    cyc();
    ecall_i = 1'b0; ebreak_i = 1'b0; int_req_i = 1'b0; inst_addr_i = 32'hDEAD_0000;
    #1 check({tag, "_raddr_T1"}, csr_bus.raddr_o, 32'h300);
    cyc(); #1 check({tag, "_raddr_T2"}, csr_bus.raddr_o, 32'h305);
    cyc();
    #1 check({tag, "_we_T3"}, 32'(csr_bus.we_o), 32'h1);
    check({tag, "_waddr_T3"}, csr_bus.waddr_o, 32'h341);
    check({tag, "_mepc_T3"}, csr_bus.wdata_o, pc);
    cyc();
    if (inject) begin
      ex_we_i = 1'b1; ex_waddr_i = 32'h305; ex_wdata_i = 32'hDEAD_BEEF;
    end
    #1 check({tag, "_waddr_T4"}, csr_bus.waddr_o, 32'h342);
    check({tag, "_mcause_T4"}, csr_bus.wdata_o, cause);
    cyc();
    ex_we_i = 1'b0;
    #1 check({tag, "_waddr_T5"}, csr_bus.waddr_o, 32'h300);
    check({tag, "_mstatus_T5"}, csr_bus.wdata_o, status);
    cyc();
    #1 check({tag, "_jump_T6"}, 32'(jump_o), 32'h1);
    check({tag, "_jaddr_T6"}, jump_addr_o, jaddr);
    check({tag, "_hold_T6"}, 32'(hold_o), 32'h1);
    cyc();
    #1 check({tag, "_jump_T7"}, 32'(jump_o), 32'h0);
    check({tag, "_hold_T7"}, 32'(hold_o), 32'h0);
    check({tag, "_jaddr_T7"}, jump_addr_o, 32'h0);
  endtask

  initial begin
    rst = 1'b0; model_clr = 1'b1;
    ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0; int_req_i = 1'b0;
    inst_addr_i = '0; ex_we_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0; ex_raddr_i = '0;
    cyc(); cyc();
    ecall_i = 1'b1;
    #1 check("rst_hold", 32'(hold_o), 32'h0);
    check("rst_jump", 32'(jump_o), 32'h0);
    check("rst_jaddr", jump_addr_o, 32'h0);
    ecall_i = 1'b0;
    cyc();
    rst = 1'b1; model_clr = 1'b0;
    cyc();

    // Pipeline passthrough in IDLE, loading mtvec=0x100 and mstatus=0x8.
    ex_we_i = 1'b1; ex_waddr_i = 32'h305; ex_wdata_i = 32'h100; ex_raddr_i = 32'h1234_5678;
    #1 check("pass_we", 32'(csr_bus.we_o), 32'h1);
    check("pass_waddr", csr_bus.waddr_o, 32'h305);
    check("pass_wdata", csr_bus.wdata_o, 32'h100);
    check("pass_raddr", csr_bus.raddr_o, 32'h1234_5678);
    cyc();
    ex_we_i = 1'b0; ex_raddr_i = '0;
    pipe_wr(32'h300, 32'h8);

    // ecall at PC 0x40.
    ecall_i = 1'b1; inst_addr_i = 32'h40;
    trap_seq("ecall", 32'h40, 32'd11, 32'h80, 32'h100, 1'b0);
    check("ecall_m_epc", m_epc, 32'h40);
    check("ecall_m_cause", m_cause, 32'd11);
    check("ecall_m_status", m_status, 32'h80);

    // mret back to 0x40, mstatus 0x80 -> 0x88.
    mret_i = 1'b1; inst_addr_i = 32'h44;
    #1 check("mret_hold_T", 32'(hold_o), 32'h1);
    cyc(); mret_i = 1'b0;
    #1 check("mret_raddr_T1", csr_bus.raddr_o, 32'h300);
    cyc(); #1 check("mret_raddr_T2", csr_bus.raddr_o, 32'h341);
    cyc();
    #1 check("mret_we_T3", 32'(csr_bus.we_o), 32'h1);
    check("mret_waddr_T3", csr_bus.waddr_o, 32'h300);
    check("mret_wdata_T3", csr_bus.wdata_o, 32'h88);
    cyc();
    #1 check("mret_jump_T4", 32'(jump_o), 32'h1);
    check("mret_jaddr_T4", jump_addr_o, 32'h40);
    cyc();
    #1 check("mret_hold_T5", 32'(hold_o), 32'h0);
    check("mret_jump_T5", 32'(jump_o), 32'h0);

    // Interrupt masked, then unmasked by a pipeline mstatus write.
    pipe_wr(32'h300, 32'h0);
    int_req_i = 1'b1;
    #1 check("int_masked_hold", 32'(hold_o), 32'h0);
    cyc();
    ex_we_i = 1'b1; ex_waddr_i = 32'h300; ex_wdata_i = 32'h8;
    #1 check("int_unmask_cycle_hold", 32'(hold_o), 32'h0);
    cyc();
    ex_we_i = 1'b0; inst_addr_i = 32'h50;
    trap_seq("int", 32'h50, 32'h8000_0007, 32'h80, 32'h100, 1'b0);

    // Vectored mtvec with an interrupt.
    pipe_wr(32'h305, 32'h201);
    pipe_wr(32'h300, 32'h8);
    int_req_i = 1'b1; inst_addr_i = 32'h60;
    trap_seq("vec", 32'h60, 32'h8000_0007, 32'h80, VEC_EXP, 1'b0);

    // ecall beats a simultaneous interrupt; a pipeline write during WR_CAUSE is dropped.
    pipe_wr(32'h300, 32'h8);
    ecall_i = 1'b1; int_req_i = 1'b1; inst_addr_i = 32'h70;
    trap_seq("both", 32'h70, 32'd11, 32'h80, 32'h200, 1'b1);
    check("both_mtvec_kept", m_tvec, 32'h201);
    check("both_m_cause", m_cause, 32'd11);

    // Reset at T+4 of an ebreak trap.
    status_wr_snap = n_status_wr;
    ebreak_i = 1'b1; inst_addr_i = 32'h80;
    cyc(); ebreak_i = 1'b0;
    cyc(); cyc(); cyc();
    #1 check("rstmid_hold_before", 32'(hold_o), 32'h1);
    rst = 1'b0;
    #1 check("rstmid_hold", 32'(hold_o), 32'h0);
    check("rstmid_jump", 32'(jump_o), 32'h0);
    check("rstmid_jaddr", jump_addr_o, 32'h0);
    check("rstmid_we", 32'(csr_bus.we_o), 32'h0);
    cyc();
    rst = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    ex_raddr_i = 32'h342;
    #1 check("rstmid_idle_raddr", csr_bus.raddr_o, 32'h342);
    check("rstmid_hold_after", 32'(hold_o), 32'h0);
    check("rstmid_no_status_wr", 32'(n_status_wr), 32'(status_wr_snap));
    check("rstmid_m_cause", m_cause, 32'd11);
    check("rstmid_m_status", m_status, 32'h80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
